// File: rtl/sh2_ext_bus_target_pkg.sv
// Shared types for the SH7604 external-bus target: FSM states and
// port-size codes (same encoding as the BCR2 AnSZ fields).
package sh2_ext_bus_target_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MREQ = 2'd1,
    VEC  = 2'd2
  } bus_tgt_state_t;

  localparam logic [1:0] PSZ_8  = 2'b01;
  localparam logic [1:0] PSZ_16 = 2'b10;
  localparam logic [1:0] PSZ_32 = 2'b11;

endpackage

// File: rtl/sh2_bus_lane_steer.sv
// Places pin-side data onto 32-bit memory lanes and extracts read data back.
// Memory lane 3 is [31:24]; low byte addresses map to high lanes (big-endian).
module sh2_bus_lane_steer
  import sh2_ext_bus_target_pkg::*;
#(
  parameter logic [1:0] PORT_SZ = PSZ_32
) (
  input  logic [1:0]  a_lo,
  input  logic        rd,
  input  logic [3:0]  we_n,
  input  logic [31:0] di,
  input  logic [31:0] mem_rd,
  output logic [3:0]  be,
  output logic [31:0] wd,
  output logic [31:0] rdata
);

  logic [31:0] rd_shr;
  logic        unused;

  assign unused = ^{a_lo, we_n, di, mem_rd};

  // For byte ports the lane index is 3-a_lo, i.e. ~a_lo.
  assign rd_shr = mem_rd >> {~a_lo, 3'b000};

  always_comb begin
    be    = '0;
    wd    = '0;
    rdata = '0;
    case (PORT_SZ)
      PSZ_16: begin
        if (a_lo[1]) begin
          be    = {2'b00, ~we_n[1:0]};
          wd    = {16'h0, di[15:0]};
          rdata = {16'h0, mem_rd[15:0]};
        end else begin
          be    = {~we_n[1:0], 2'b00};
          wd    = {di[15:0], 16'h0};
          rdata = {16'h0, mem_rd[31:16]};
        end
      end
      PSZ_8: begin
        be    = {3'b000, ~we_n[0]} << ~a_lo;
        wd    = {24'h0, di[7:0]} << {~a_lo, 3'b000};
        rdata = {24'h0, rd_shr[7:0]};
      end
      default: begin
        be    = ~we_n;
        wd    = di;
        rdata = mem_rd;
      end
    endcase
    if (rd) be = 4'hF;
  end

endmodule

// File: rtl/sh2_ext_bus_target.sv
// SH7604 external-bus responder: one chip-select area mapped onto a
// req/ack 32-bit memory port, plus interrupt-vector fetch answers.
module sh2_ext_bus_target
  import sh2_ext_bus_target_pkg::*;
#(
  parameter logic [1:0] PORT_SZ = PSZ_32,
  parameter int         ADDR_W  = 24,
  parameter bit         VEC_EN  = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic [26:0]       A,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              DO_OE,
  input  logic              BS_N,
  input  logic              CS_N,
  input  logic              RD_WR_N,
  input  logic              RD_N,
  input  logic [3:0]        WE_N,
  input  logic              IVECF_N,
  output logic              WAIT_N,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [31:0]       MEM_WD,
  output logic [3:0]        MEM_BE,
  output logic              MEM_WE,
  output logic              MEM_REQ,
  input  logic [31:0]       MEM_RD,
  input  logic              MEM_ACK,
  input  logic [7:0]        VEC_DI,
  output logic [3:0]        VEC_LVL,
  output logic              VEC_ACK
);

  typedef struct packed {
    bus_tgt_state_t    state;
    logic [3:0]        a_lo;
    logic              rd;
    logic [31:0]       dout;
    logic              dout_oe;
    logic              wait_n;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic [3:0]        vec_lvl;
    logic              vec_ack;
  } regs_t;

  regs_t       r, n;
  logic        idle;
  logic [3:0]  st_be;
  logic [31:0] st_wd, st_rdata;
  logic        unused;

  // Strobes and CE_F are not needed: BS_N/CS_N on CE_R fully qualify a cycle.
  assign unused = ^{CE_F, RD_N, A};
  assign idle   = (r.state == IDLE);

  // In IDLE the steer sees live pins (for placement at accept); afterwards it
  // sees the latched address so read data is extracted from the right lane.
  sh2_bus_lane_steer #(.PORT_SZ(PORT_SZ)) u_steer (
    .a_lo   (idle ? A[1:0] : r.a_lo[1:0]),
    .rd     (idle ? RD_WR_N : r.rd),
    .we_n   (WE_N),
    .di     (DI),
    .mem_rd (MEM_RD),
    .be     (st_be),
    .wd     (st_wd),
    .rdata  (st_rdata)
  );

  always_comb begin
    n         = r;
    n.vec_ack = 1'b0;
    unique case (r.state)
      IDLE: begin
        if (CE_R && !BS_N && VEC_EN && !IVECF_N) begin
          n.state = VEC;
          n.a_lo  = A[3:0];
        end else if (CE_R && !BS_N && !CS_N) begin
          n.state   = MREQ;
          n.a_lo    = A[3:0];
          n.rd      = RD_WR_N;
          n.wait_n  = 1'b0;
          n.mem_req = 1'b1;
          n.dout_oe = RD_WR_N;
          n.mem_we  = !RD_WR_N;
          n.mem_be  = st_be;
          n.mem_wd  = st_wd;
          n.mem_a   = A[ADDR_W+1:2];
        end else if (CE_R && CS_N && IVECF_N) begin
          n.dout_oe = 1'b0;
        end
      end
      MREQ: begin
        if (MEM_ACK) begin
          n.mem_req = 1'b0;
          n.wait_n  = 1'b1;
          if (r.rd) n.dout = st_rdata;
          n.state   = IDLE;
        end
      end
      VEC: begin
        n.dout    = {24'h0, VEC_DI};
        n.vec_lvl = r.a_lo;
        n.vec_ack = 1'b1;
        n.dout_oe = 1'b1;
        n.state   = IDLE;
      end
      default: n.state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r        <= '0;
      r.state  <= IDLE;
      r.wait_n <= 1'b1;
    end else begin
      r <= n;
    end
  end

  assign DO      = r.dout;
  assign DO_OE   = r.dout_oe;
  assign WAIT_N  = r.wait_n;
  assign MEM_A   = r.mem_a;
  assign MEM_WD  = r.mem_wd;
  assign MEM_BE  = r.mem_be;
  assign MEM_WE  = r.mem_we;
  assign MEM_REQ = r.mem_req;
  assign VEC_LVL = r.vec_lvl;
  assign VEC_ACK = r.vec_ack;

endmodule

// File: tb/tb_sh2_ext_bus_target.sv
// Drives 8/16/32-bit instances with shared bus stimulus and checks each
// against a byte-lane reference model.
module tb_sh2_ext_bus_target;

  logic        clk, rst_n, ce_r, ce_f;
  logic [26:0] a;
  logic [31:0] di, mem_rd;
  logic        bs_n, cs_n, rd_wr_n, rd_n, ivecf_n, mem_ack;
  logic [3:0]  we_n;
  logic [7:0]  vec_di;

  logic [31:0] do_w   [3];
  logic        oe_w   [3];
  logic        wait_w [3];
  logic [23:0] ma_w   [3];
  logic [31:0] wd_w   [3];
  logic [3:0]  be_w   [3];
  logic        we_w   [3];
  logic        req_w  [3];
  logic [3:0]  lvl_w  [3];
  logic        vack_w [3];

  // instance k has port size code k+1: 0=8b, 1=16b, 2=32b
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sh2_ext_bus_target #(.PORT_SZ(2'(g + 1)), .ADDR_W(24), .VEC_EN(1'b1)) u_dut (
      .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f), .A(a), .DI(di),
      .DO(do_w[g]), .DO_OE(oe_w[g]), .BS_N(bs_n), .CS_N(cs_n), .RD_WR_N(rd_wr_n),
      .RD_N(rd_n), .WE_N(we_n), .IVECF_N(ivecf_n), .WAIT_N(wait_w[g]),
      .MEM_A(ma_w[g]), .MEM_WD(wd_w[g]), .MEM_BE(be_w[g]), .MEM_WE(we_w[g]),
      .MEM_REQ(req_w[g]), .MEM_RD(mem_rd), .MEM_ACK(mem_ack), .VEC_DI(vec_di),
      .VEC_LVL(lvl_w[g]), .VEC_ACK(vack_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_req_rise = 0, n_mem_txn = 0;
  logic req_prev = 1'b0;
  logic [31:0] exp_do [3];

  always @(posedge clk) begin
    if (req_w[2] && !req_prev) n_req_rise <= n_req_rise + 1;
    req_prev <= req_w[2];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Byte-lane view: the pin bytes of a port of nb bytes land on memory lanes
  // base..base+nb-1, where base follows from big-endian byte addressing.
  task automatic model(input int k, input logic [26:0] ad, input bit rd,
                       input logic [3:0] wn, input logic [31:0] d, input logic [31:0] m,
                       output logic [3:0] be, output logic [31:0] wd, output logic [31:0] dout);
    int nb, base;
    nb   = (k == 2) ? 4 : (k == 1) ? 2 : 1;
    base = (k == 2) ? 0 : (k == 1) ? (ad[1] ? 0 : 2) : 3 - int'(ad[1:0]);
    be = '0; wd = '0; dout = '0;
    for (int i = 0; i < nb; i++) begin
      wd[8*(base+i) +: 8] = d[8*i +: 8];
      if (!wn[i]) be[base+i] = 1'b1;
      dout[8*i +: 8] = m[8*(base+i) +: 8];
    end
    if (rd) be = 4'hF;
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.do%0d", tag, k), do_w[k], 0);
      chk($sformatf("%s.oe%0d", tag, k), 32'(oe_w[k]), 0);
      chk($sformatf("%s.wait%0d", tag, k), 32'(wait_w[k]), 1);
      chk($sformatf("%s.req%0d", tag, k), 32'(req_w[k]), 0);
      chk($sformatf("%s.we%0d", tag, k), 32'(we_w[k]), 0);
      chk($sformatf("%s.be%0d", tag, k), 32'(be_w[k]), 0);
      chk($sformatf("%s.ma%0d", tag, k), 32'(ma_w[k]), 0);
      chk($sformatf("%s.wd%0d", tag, k), wd_w[k], 0);
      chk($sformatf("%s.lvl%0d", tag, k), 32'(lvl_w[k]), 0);
      chk($sformatf("%s.vack%0d", tag, k), 32'(vack_w[k]), 0);
    end
  endtask

  task automatic drive_accept(input bit vec, input bit rd, input logic [26:0] ad,
                              input logic [3:0] wn, input logic [31:0] d,
                              input logic [31:0] m, input logic [7:0] vd);
    @(negedge clk);
    a = ad; rd_wr_n = rd; rd_n = !rd; we_n = rd ? 4'hF : wn; di = d;
    mem_rd = m; vec_di = vd; bs_n = 1'b0; ce_r = 1'b1;
    cs_n = vec; ivecf_n = !vec;
    @(negedge clk);
    bs_n = 1'b1; ce_r = 1'b0;
  endtask

  task automatic txn(input bit vec, input bit rd, input logic [26:0] ad, input logic [3:0] wn,
                     input logic [31:0] d, input logic [31:0] m, input logic [7:0] vd,
                     input int dly, input bit gap);
    logic [3:0] be_e [3];
    logic [31:0] wd_e [3], do_e [3];
    for (int k = 0; k < 3; k++) model(k, ad, rd, wn, d, m, be_e[k], wd_e[k], do_e[k]);
    drive_accept(vec, rd, ad, wn, d, m, vd);
    if (vec) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("vacc.wait%0d", k), 32'(wait_w[k]), 1);
        chk($sformatf("vacc.req%0d", k), 32'(req_w[k]), 0);
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_do[k] = {24'h0, vd};
        chk($sformatf("vec.do%0d", k), do_w[k], exp_do[k]);
        chk($sformatf("vec.lvl%0d", k), 32'(lvl_w[k]), 32'(ad[3:0]));
        chk($sformatf("vec.ack%0d", k), 32'(vack_w[k]), 1);
        chk($sformatf("vec.oe%0d", k), 32'(oe_w[k]), 1);
        chk($sformatf("vec.wait%0d", k), 32'(wait_w[k]), 1);
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk($sformatf("vec.ack1_%0d", k), 32'(vack_w[k]), 0);
    end else begin
      n_mem_txn++;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("acc.req%0d", k), 32'(req_w[k]), 1);
        chk($sformatf("acc.wait%0d", k), 32'(wait_w[k]), 0);
        chk($sformatf("acc.ma%0d", k), 32'(ma_w[k]), 32'(ad[25:2]));
        chk($sformatf("acc.we%0d", k), 32'(we_w[k]), 32'(!rd));
        chk($sformatf("acc.be%0d", k), 32'(be_w[k]), 32'(be_e[k]));
        if (!rd) chk($sformatf("acc.wd%0d", k), wd_w[k], wd_e[k]);
        chk($sformatf("acc.oe%0d", k), 32'(oe_w[k]), 32'(rd));
      end
      for (int c = 0; c < dly; c++) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("hold.wait%0d", k), 32'(wait_w[k]), 0);
          chk($sformatf("hold.req%0d", k), 32'(req_w[k]), 1);
        end
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (rd) exp_do[k] = do_e[k];
        chk($sformatf("done.req%0d", k), 32'(req_w[k]), 0);
        chk($sformatf("done.wait%0d", k), 32'(wait_w[k]), 1);
        chk($sformatf("done.do%0d", k), do_w[k], exp_do[k]);
      end
    end
    if (gap) begin
      cs_n = 1'b1; ivecf_n = 1'b1; ce_r = 1'b1;
      @(negedge clk);
      ce_r = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("gap.oe%0d", k), 32'(oe_w[k]), 0);
        chk($sformatf("gap.do%0d", k), do_w[k], exp_do[k]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ce_r = 1'b0; ce_f = 1'b0; a = '0; di = '0; mem_rd = '0;
    bs_n = 1'b1; cs_n = 1'b1; rd_wr_n = 1'b1; rd_n = 1'b1; ivecf_n = 1'b1;
    we_n = 4'hF; mem_ack = 1'b0; vec_di = '0;
    for (int k = 0; k < 3; k++) exp_do[k] = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    txn(0, 0, 27'h000104, 4'h0, 32'hDEADBEEF, 32'h0, 8'h0, 2, 1);
    chk("spec32.ma", 32'(ma_w[2]), 32'h41);
    chk("spec32.wd", wd_w[2], 32'hDEADBEEF);
    txn(0, 1, 27'h000002, 4'hF, 32'h0, 32'h1234ABCD, 8'h0, 4, 1);
    chk("spec16.do", do_w[1], 32'h0000ABCD);
    txn(0, 0, 27'h000001, 4'b1110, 32'h0000005A, 32'h0, 8'h0, 1, 1);
    chk("spec8.be", 32'(be_w[0]), 32'h4);
    chk("spec8.wd", 32'(wd_w[0][23:16]), 32'h5A);
    txn(1, 1, 27'h00000B, 4'hF, 32'h0, 32'h0, 8'h47, 0, 1);
    chk("specvec.do", do_w[2], 32'h47);
    chk("specvec.lvl", 32'(lvl_w[2]), 32'hB);
    txn(0, 0, 27'h000300, 4'hF, 32'h11223344, 32'h0, 8'h0, 0, 1);

    // back-to-back, ack on first MREQ clock, no idle cycle between
    txn(0, 1, 27'h000010, 4'hF, 32'h0, 32'hCAFEF00D, 8'h0, 0, 0);
    txn(0, 0, 27'h000013, 4'h3, 32'h89ABCDEF, 32'h0, 8'h0, 0, 0);
    txn(0, 1, 27'h000016, 4'hF, 32'h0, 32'h5566AA77, 8'h0, 0, 1);

    // reset mid-request, then a stray ack must be ignored
    drive_accept(0, 1, 27'h000020, 4'hF, 32'h0, 32'hFEEDFACE, 8'h0);
    n_mem_txn++;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) exp_do[k] = '0;
    chk_reset("abort");
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk_reset("lateack");

    for (int t = 0; t < 60; t++) begin
      txn(($urandom_range(0, 7) == 0), $urandom_range(0, 1), 27'($urandom()),
          4'($urandom()), $urandom(), $urandom(), 8'($urandom()),
          $urandom_range(0, 5), $urandom_range(0, 1));
    end

    repeat (2) @(negedge clk);
    chk("accept_count", 32'(n_req_rise), 32'(n_mem_txn));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
